// File: rtl/sd_cmd_tx_pkg.sv
// sd_cmd_tx_pkg: shared constants and FSM state type for the SD CMD line blocks
package sd_cmd_tx_pkg;
    localparam int SdCmdFrameBits = 48;
    localparam int SdCmdCrcBits = 7;
    localparam logic [SdCmdCrcBits-1:0] SdCrc7Poly = 7'h09;
    localparam int SdCmdCrcPos = 40;
    localparam int SdCmdEndPos = 47;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND, ST_GAP} sd_cmd_tx_state_e;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB-first input, zero initial value
module sd_crc7 import sd_cmd_tx_pkg::*; (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    bit_i,
    output logic [SdCmdCrcBits-1:0] crc_o
);
    logic fb;
    assign fb = bit_i ^ crc_o[SdCmdCrcBits-1];
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) crc_o <= '0;
        else if (en_i) crc_o <= {crc_o[SdCmdCrcBits-2:0], 1'b0} ^ (fb ? SdCrc7Poly : '0);
    end
endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: builds the 48-bit SD command token and shifts it onto CMD on falling-edge ticks
module sd_cmd_tx import sd_cmd_tx_pkg::*; #(
    parameter int PostIdleBits = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clk_en_n_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cmd_o,
    output logic        cmd_en_o
);
    localparam int GapW = PostIdleBits > 1 ? $clog2(PostIdleBits) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(PostIdleBits > 0 ? PostIdleBits - 1 : 0);
    sd_cmd_tx_state_e state, state_d;
    logic [39:0] sreg, sreg_d;
    logic [5:0] bit_cnt, bit_d, nxt;
    logic [GapW-1:0] gap_cnt, gap_d;
    logic cmd_d, en_d, done_d, busy_d, crc_clr, crc_en;
    logic [SdCmdCrcBits-1:0] crc;
    sd_crc7 u_crc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(crc_clr),
        .en_i   (crc_en),
        .bit_i  (sreg[39]),
        .crc_o  (crc)
    );
    assign nxt = bit_cnt + 6'd1;
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        bit_d   = bit_cnt;
        gap_d   = gap_cnt;
        cmd_d   = cmd_o;
        en_d    = cmd_en_o;
        done_d  = 1'b0;
        busy_d  = busy_o;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        case (state)
            ST_IDLE: if (start_i) begin
                sreg_d  = {2'b01, cmd_index_i, cmd_arg_i};
                crc_clr = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (clk_en_n_i) begin
                cmd_d   = sreg[39];
                en_d    = 1'b1;
                crc_en  = 1'b1;
                sreg_d  = {sreg[38:0], 1'b0};
                bit_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: if (clk_en_n_i) begin
                if (bit_cnt == 6'(SdCmdEndPos)) begin
                    en_d    = 1'b0;
                    cmd_d   = 1'b1;
                    done_d  = 1'b1;
                    bit_d   = '0;
                    gap_d   = '0;
                    busy_d  = PostIdleBits != 0;
                    state_d = PostIdleBits != 0 ? ST_GAP : ST_IDLE;
                end else begin
                    bit_d = nxt;
                    // CRC is final once bit 39 has been fed; it is then read out MSB-first
                    if (nxt < 6'(SdCmdCrcPos)) begin
                        cmd_d  = sreg[39];
                        crc_en = 1'b1;
                        sreg_d = {sreg[38:0], 1'b0};
                    end else begin
                        cmd_d = nxt < 6'(SdCmdEndPos) ? crc[3'(SdCmdEndPos - 1 - int'(nxt))] : 1'b1;
                    end
                end
            end
            ST_GAP: if (clk_en_n_i) begin
                gap_d   = gap_cnt == GapLast ? '0 : gap_cnt + 1'b1;
                busy_d  = gap_cnt != GapLast;
                state_d = gap_cnt == GapLast ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            cmd_o    <= 1'b1;
            cmd_en_o <= 1'b0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_d;
            sreg     <= sreg_d;
            bit_cnt  <= bit_d;
            gap_cnt  <= gap_d;
            cmd_o    <= cmd_d;
            cmd_en_o <= en_d;
            done_o   <= done_d;
            busy_o   <= busy_d;
        end
    end
endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Serializes SD host commands onto the CMD line. The block takes a command index and 32-bit argument from the command sequencer and builds the 48-bit SD command token with start, transmission, CRC7 and end bits. It shifts the token out MSB-first, paced by the falling-edge enable pulse from the SD clock generator, so CMD changes on the falling SD clock edge. It sits between the command sequencer and the CMD pad driver.

## Interface
- `PostIdleBits`, default 8: number of SD clock periods CMD stays released after the end bit before a new command is accepted (N_CC).
- `clk_i` input 1: system clock; same clock that drives the SD clock generator.
- `rst_ni` input 1: reset, synchronous, active-low.
- `clk_en_n_i` input 1: high when the next `clk_i` edge coincides with a falling SD clock edge; constant high in divide-by-1 mode.
- `start_i` input 1: command request; accepted only while `busy_o` is low.
- `cmd_index_i` input 6: command index, sampled on accept.
- `cmd_arg_i` input 32: command argument, sampled on accept.
- `busy_o` output 1: high from the cycle after accept until the post-idle gap is complete.
- `done_o` output 1: one-cycle pulse when the end bit has finished.
- `cmd_o` output 1: CMD line value.
- `cmd_en_o` output 1: CMD output-driver enable.

## Operation
- FSM states:
  - IDLE: `busy_o`=0, `cmd_o`=1, `cmd_en_o`=0.
  - WAIT: request accepted, waiting for the first tick.
  - SEND: bit counter runs 0..47.
  - GAP: tick counter runs 0..`PostIdleBits`-1.
- Accept: in IDLE with `start_i`=1, latch `{2'b01, index, arg}` into a 40-bit shift register, clear CRC, go to WAIT.
- A tick is any cycle with `clk_en_n_i`=1.
- WAIT + tick: register `cmd_o`=0 (start bit) and `cmd_en_o`=1, go to SEND with bit counter 0.
- SEND + tick: advance one bit.
  - Bits 0..39 come from the shift register and feed the CRC.
  - Bits 40..46 are CRC7 MSB-first, generator x^7+x^3+1, initial value 0.
  - Bit 47 is 1 (end bit).
- Tick that ends bit 47:
  - `cmd_en_o`=0, `cmd_o`=1.
  - `done_o` pulses for the following cycle.
  - Go to GAP, or to IDLE if `PostIdleBits`=0.
- GAP: count `PostIdleBits` ticks with the line released, then go to IDLE.
- `start_i` while `busy_o`=1 is ignored. No queuing.
- Index and argument inputs are don't-care outside the accept cycle.

## Timing
- Reset values:
  - `busy_o`=0, `done_o`=0, `cmd_o`=1, `cmd_en_o`=0.
  - FSM in IDLE, counters 0, CRC 0.
- All outputs are registered.
- Accept at cycle T: `busy_o`=1 from T+1.
- Start-bit timing:
  - A tick in the accept cycle itself does not start transmission.
  - The first tick at cycle E ≥ T+1 places the start bit on `cmd_o` from E+1.
- Each bit is held from one tick to the next. Each bit lasts exactly one SD clock period, or one `clk_i` cycle in divide-by-1 mode.
- `cmd_en_o` is high for exactly 48 ticks.
- Latency from accept to end of the end bit: (ticks until first tick) + 48 ticks.
- Synchronous reset mid-frame: all outputs return to reset values on the next edge. Partial frames are not resumed.
- If `clk_en_n_i` stops (SD clock paused), state and outputs hold indefinitely. No timeout.

## Structure
- Shared package entries:
  - `SdCmdFrameBits`=48.
  - `SdCmdCrcBits`=7.
  - CRC7 polynomial constant 7'h09.
  - FSM state enum `sd_cmd_tx_state_e`.
  - Bit-position constants for the CRC field (40) and end bit (47).
- Sub-module `sd_crc7`: serial CRC7 with inputs `clk_i`, `rst_ni`, `clear_i`, `en_i`, `bit_i` and output `crc_o[6:0]`. It is reused later by the CMD receiver for response checking.
- Top level holds the FSM, 40-bit shift register, 6-bit bit counter and gap counter.

## Test plan
- `clk_en_n_i` tied high, CMD0 with arg 0x00000000: `cmd_o` sequence 0x40_00000000_95 over 48 consecutive cycles, then `done_o` pulse, `busy_o` low after 8 more cycles.
- CMD8 with arg 0x000001AA and `clk_en_n_i` pulsing every 4 cycles: frame 0x48_000001AA_87, each bit held 4 cycles, `cmd_en_o` high for 192 cycles.
- CMD17 with arg 0x00000000, and `start_i` re-asserted with index 55 during SEND and GAP: only frame 0x51_00000000_55 appears, and the second request is dropped.
- `start_i` coincident with a tick in IDLE: start bit appears only after the next tick, not the current one.
- Reset asserted at bit 20: next cycle `cmd_o`=1, `cmd_en_o`=0, `busy_o`=0. A new CMD0 afterwards yields a clean 0x40_00000000_95.
- `PostIdleBits`=0 and `clk_en_n_i` held low mid-frame for 100 cycles: outputs hold during the stall, and a back-to-back command is accepted the cycle after `done_o`.
